sw_irq_ctrl: RTL and testbench

Switch-input peripheral of the miriscv system: takes the raw board switch vector, synchronises and debounces it, and raises an interrupt request line to the core whenever the debounced value changes. It sits between the top-level switch pins and the core's interrupt request bit 0, with a small memory-mapped register window on the data bus. Interrupt completion from the core clears the pending request.

---
 rtl/sw_irq_pkg.sv | 14 +
 rtl/sync_2ff.sv | 27 ++
 rtl/sw_irq_ctrl.sv | 135 +++++++++++++
 tb/tb_sw_irq_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sw_irq_pkg.sv
// Shared definitions for the switch-input interrupt peripheral:
// register offsets and the debounce FSM state encoding.
package sw_irq_pkg;

  localparam logic [3:0] SW_VALUE_ADDR  = 4'h0;
  localparam logic [3:0] SW_STATUS_ADDR = 4'h4;
  localparam logic [3:0] SW_CTRL_ADDR   = 4'h8;

  typedef enum logic {
    DEB_IDLE,
    DEB_COUNT
  } deb_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Parameterised-width two-flop synchroniser for bringing asynchronous
// inputs into the clk_i domain.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/sw_irq_ctrl.sv
// Switch peripheral: synchronises and debounces the switch vector, raises an
// interrupt on every accepted change and exposes a small register window.
module sw_irq_ctrl
  import sw_irq_pkg::*;
#(
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [SW_W-1:0] sw_i,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [3:0]      addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o,
  output logic            int_req_o,
  input  logic            int_fin_i
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  // Commit on the edge where the counter would reach DEBOUNCE_CYCLES-1; the
  // IDLE cycle that latched the candidate counts as the first stable cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [SW_W-1:0]  w_sw_sync;
  deb_state_t       r_state, w_state_next;
  logic [SW_W-1:0]  r_cand, w_cand_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [SW_W-1:0]  r_sw_stable, w_sw_stable_next;
  logic             w_change;
  logic             r_pending;
  logic             r_irq_en;
  logic [31:0]      r_rdata, w_rdata_next;
  logic             w_wr, w_rd, w_clear;
  logic             w_unused_wdata;

  sync_2ff #(.W(SW_W)) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (sw_i),
    .q_o     (w_sw_sync)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= DEB_IDLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_sw_stable <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cand      <= w_cand_next;
      r_cnt       <= w_cnt_next;
      r_sw_stable <= w_sw_stable_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cand_next      = r_cand;
    w_cnt_next       = r_cnt;
    w_sw_stable_next = r_sw_stable;
    w_change         = 1'b0;
    case (r_state)
      DEB_IDLE: begin
        w_cnt_next = '0;
        if (w_sw_sync != r_sw_stable) begin
          w_cand_next  = w_sw_sync;
          w_state_next = DEB_COUNT;
        end
      end
      DEB_COUNT: begin
        if (w_sw_sync != r_cand) begin
          w_cnt_next   = '0;
          w_state_next = DEB_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_next       = '0;
          w_sw_stable_next = r_cand;
          w_change         = 1'b1;
          w_state_next     = DEB_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = DEB_IDLE;
      end
    endcase
  end

  assign w_wr    = req_i & we_i;
  assign w_rd    = req_i & ~we_i;
  assign w_clear = int_fin_i | (w_wr && addr_i == SW_STATUS_ADDR && wdata_i[0]);

  // A new change beats a simultaneous clear so no event is ever lost.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pending <= 1'b0;
      r_irq_en  <= 1'b1;
    end else begin
      if (w_change)
        r_pending <= 1'b1;
      else if (w_clear)
        r_pending <= 1'b0;
      if (w_wr && addr_i == SW_CTRL_ADDR)
        r_irq_en <= wdata_i[0];
    end
  end

  always_comb begin
    w_rdata_next = r_rdata;
    if (w_rd) begin
      case (addr_i)
        SW_VALUE_ADDR:  w_rdata_next = 32'(r_sw_stable);
        SW_STATUS_ADDR: w_rdata_next = {31'b0, r_pending};
        SW_CTRL_ADDR:   w_rdata_next = {31'b0, r_irq_en};
        default:        w_rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_rdata <= '0;
    else
      r_rdata <= w_rdata_next;
  end

  assign rdata_o        = r_rdata;
  assign int_req_o      = r_pending & r_irq_en;
  assign w_unused_wdata = ^wdata_i[31:1];

endmodule

// File: tb/tb_sw_irq_ctrl.sv
// Directed bench for sw_irq_ctrl with an 8-cycle debounce window.
module tb_sw_irq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [15:0] sw_i;
  logic        req_i;
  logic        we_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        int_req_o;
  logic        int_fin_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd_val;

  sw_irq_ctrl #(.SW_W(16), .DEBOUNCE_CYCLES(8)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .sw_i      (sw_i),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .int_req_o (int_req_o),
    .int_fin_i (int_fin_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    step(1);
    req_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    step(1);
    req_i = 1'b0; we_i = 1'b0; wdata_i = '0;
  endtask

  initial begin
    rst_n_i = 1'b0; sw_i = 16'h1111; req_i = 1'b0; we_i = 1'b0;
    addr_i = '0; wdata_i = '0; int_fin_i = 1'b0;
    step(3);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_irq", {31'b0, int_req_o}, 32'h0);

    // Release; commit is due on the 10th edge
    rst_n_i = 1'b1;
    step(8);
    rd(4'h0, rd_val);
    check("pre_commit_val", rd_val, 32'h0);
    check("pre_commit_irq", {31'b0, int_req_o}, 32'h0);
    step(1);
    check("commit_irq", {31'b0, int_req_o}, 32'h1);
    rd(4'h0, rd_val);
    check("value_1111", rd_val, 32'h1111);

    // Interrupt completion
    int_fin_i = 1'b1; step(1); int_fin_i = 1'b0;
    check("fin_irq", {31'b0, int_req_o}, 32'h0);
    rd(4'h4, rd_val);
    check("fin_status", rd_val, 32'h0);

    // Short glitch must not commit
    sw_i = 16'h1011; step(2); sw_i = 16'h1111;
    step(12);
    check("glitch_irq", {31'b0, int_req_o}, 32'h0);
    rd(4'h0, rd_val);
    check("glitch_value", rd_val, 32'h1111);

    // Completion pulse on the commit edge: set wins
    sw_i = 16'h1110;
    step(9);
    check("pre_setwin_irq", {31'b0, int_req_o}, 32'h0);
    int_fin_i = 1'b1; step(1); int_fin_i = 1'b0;
    check("setwin_irq", {31'b0, int_req_o}, 32'h1);
    rd(4'h4, rd_val);
    check("setwin_status", rd_val, 32'h1);
    rd(4'h0, rd_val);
    check("value_1110", rd_val, 32'h1110);
    int_fin_i = 1'b1; step(1); int_fin_i = 1'b0;
    check("fin2_irq", {31'b0, int_req_o}, 32'h0);

    // Masking, unmasking and write-1-to-clear
    wr(4'h8, 32'h0);
    rd(4'h8, rd_val);
    check("ctrl_off", rd_val, 32'h0);
    sw_i = 16'h1100;
    step(12);
    check("masked_irq", {31'b0, int_req_o}, 32'h0);
    rd(4'h4, rd_val);
    check("masked_status", rd_val, 32'h1);
    wr(4'h8, 32'h1);
    check("unmask_irq", {31'b0, int_req_o}, 32'h1);
    rd(4'h8, rd_val);
    check("ctrl_on", rd_val, 32'h1);
    wr(4'h4, 32'h1);
    check("w1c_irq", {31'b0, int_req_o}, 32'h0);
    rd(4'h4, rd_val);
    check("w1c_status", rd_val, 32'h0);

    // Read-only and unmapped locations
    wr(4'h0, 32'hFFFF_FFFF);
    rd(4'h0, rd_val);
    check("value_ro", rd_val, 32'h1100);
    step(3);
    check("rdata_hold", rdata_o, 32'h1100);
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'hC, rd_val);
    check("unmapped_rd", rd_val, 32'h0);

    // Asynchronous reset in the middle of a count
    sw_i = 16'h1101;
    step(12);
    check("pre_rst_irq", {31'b0, int_req_o}, 32'h1);
    rd(4'h0, rd_val);
    check("value_1101", rd_val, 32'h1101);
    sw_i = 16'h00FF;
    step(5);
    #2 rst_n_i = 1'b0;
    #1;
    check("async_rdata", rdata_o, 32'h0);
    check("async_irq", {31'b0, int_req_o}, 32'h0);
    step(2);
    rst_n_i = 1'b1;
    step(8);
    rd(4'h0, rd_val);
    check("post_rst_val", rd_val, 32'h0);
    check("post_rst_irq", {31'b0, int_req_o}, 32'h0);
    step(1);
    check("post_rst_commit", {31'b0, int_req_o}, 32'h1);
    rd(4'h0, rd_val);
    check("value_00ff", rd_val, 32'h00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
